// File: rtl/mem_port_arbiter.sv
// Purpose: shares one fixed-latency memory between the CPU control FSM and a DMA/loader port.
// Latency: ready pulses MEM_LAT+2 cycles after the grant edge; back-to-back accesses take MEM_LAT+3 cycles.
// Backpressure: requests are held by the requester until its ready pulse; nothing is granted while busy.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_LIM = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  localparam logic [3:0] LAT_LOAD   = 4'(MEM_LAT - 1);
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIM);

  logic [1:0] state;
  logic [3:0] lat_cnt;
  logic [3:0] starve_cnt;
  logic       we_q;
  logic       grant_dma;

  // DMA wins when it is alone, or when the CPU has starved it STARVE_LIM times in a row.
  always_comb begin
    grant_dma = dma_req && (!cpu_req || (starve_cnt == STARVE_MAX));
  end

  // Outputs are decoded from registered state only; no request-to-output path.
  assign busy      = (state != IDLE);
  assign mem_en    = (state == ISSUE);
  assign mem_we    = (state == ISSUE) && we_q;
  assign cpu_ready = (state == RESP) && !owner;
  assign dma_ready = (state == RESP) && owner;

  // Access sequencer: grant and latch in IDLE, strobe in ISSUE, count latency in WAIT, pulse in RESP.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      lat_cnt    <= '0;
      starve_cnt <= '0;
      owner      <= 1'b0;
      we_q       <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_req || dma_req) begin
            owner     <= grant_dma;
            we_q      <= grant_dma ? dma_we    : cpu_we;
            mem_addr  <= grant_dma ? dma_addr  : cpu_addr;
            mem_wdata <= grant_dma ? dma_wdata : cpu_wdata;
            // Only a CPU grant over a waiting DMA counts toward starvation.
            if (!grant_dma && dma_req) begin
              starve_cnt <= (starve_cnt == STARVE_MAX) ? STARVE_MAX : starve_cnt + 4'd1;
            end else begin
              starve_cnt <= '0;
            end
            state <= ISSUE;
          end
        end
        ISSUE: begin
          lat_cnt <= LAT_LOAD;
          state   <= WAIT;
        end
        WAIT: begin
          if (lat_cnt == 4'd0) begin
            state <= RESP;
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Read data is captured into the owner's register on the last WAIT cycle; writes leave both untouched.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cpu_rdata <= '0;
      dma_rdata <= '0;
    end else if ((state == WAIT) && (lat_cnt == 4'd0) && !we_q) begin
      if (owner) begin
        dma_rdata <= mem_rdata;
      end else begin
        cpu_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int SL = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic        cpu_req = 1'b0, cpu_we = 1'b0, dma_req = 1'b0, dma_we = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0, dma_addr = '0, dma_wdata = '0;

  logic [31:0] cpu_rdata_o [3];
  logic [31:0] dma_rdata_o [3];
  logic [31:0] mem_addr_o  [3];
  logic [31:0] mem_wdata_o [3];
  logic [31:0] mem_rdata_i [3];
  logic        cpu_ready_o [3];
  logic        dma_ready_o [3];
  logic        mem_en_o    [3];
  logic        mem_we_o    [3];
  logic        busy_o      [3];
  logic        owner_o     [3];

  function automatic int lat_of(input int d);
    return (d == 0) ? 2 : ((d == 1) ? 1 : 15);
  endfunction

  // Three instances share stimulus: MEM_LAT 2, 1 and 15.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_port_arbiter #(
      .ADDR_W(32), .DATA_W(32),
      .MEM_LAT((g == 0) ? 2 : ((g == 1) ? 1 : 15)),
      .STARVE_LIM(SL)
    ) dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata_o[g]), .cpu_ready(cpu_ready_o[g]),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_rdata(dma_rdata_o[g]), .dma_ready(dma_ready_o[g]),
      .mem_en(mem_en_o[g]), .mem_we(mem_we_o[g]), .mem_addr(mem_addr_o[g]),
      .mem_wdata(mem_wdata_o[g]), .mem_rdata(mem_rdata_i[g]),
      .busy(busy_o[g]), .owner(owner_o[g])
    );
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %h expected %h", name, d, act, exp);
    end
  endtask

  // Memory contents as a pure function of address.
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a == 32'h40) ? 32'hDEADBEEF : ((a * 32'h9E3779B1) ^ 32'hA5A50F0F);
  endfunction

  function automatic bit pick_dma(input bit c, input bit dm, input int s);
    return dm && (!c || (s == SL));
  endfunction

  // Reference model: one transaction at a time, tracked as cycles elapsed since its grant.
  int          m_k      [3] = '{default: 0};
  bit          m_own    [3] = '{default: 0};
  bit          m_we     [3] = '{default: 0};
  logic [31:0] m_addr   [3] = '{default: '0};
  logic [31:0] m_wdata  [3] = '{default: '0};
  logic [31:0] m_crd    [3] = '{default: '0};
  logic [31:0] m_drd    [3] = '{default: '0};
  int          m_starve [3] = '{default: 0};

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int d = 0; d < 3; d++) begin
        m_k[d] <= 0; m_own[d] <= 0; m_we[d] <= 0; m_addr[d] <= '0; m_wdata[d] <= '0;
        m_crd[d] <= '0; m_drd[d] <= '0; m_starve[d] <= 0;
      end
    end else begin
      for (int d = 0; d < 3; d++) begin
        if (m_k[d] == 0) begin
          if (cpu_req || dma_req) begin
            if (pick_dma(cpu_req, dma_req, m_starve[d])) begin
              m_own[d] <= 1; m_we[d] <= dma_we; m_addr[d] <= dma_addr; m_wdata[d] <= dma_wdata;
              m_starve[d] <= 0;
            end else begin
              m_own[d] <= 0; m_we[d] <= cpu_we; m_addr[d] <= cpu_addr; m_wdata[d] <= cpu_wdata;
              m_starve[d] <= dma_req ? ((m_starve[d] >= SL) ? SL : m_starve[d] + 1) : 0;
            end
            m_k[d] <= 1;
          end
        end else begin
          if ((m_k[d] == lat_of(d) + 1) && !m_we[d]) begin
            if (m_own[d]) m_drd[d] <= mem_f(m_addr[d]);
            else          m_crd[d] <= mem_f(m_addr[d]);
          end
          m_k[d] <= (m_k[d] == lat_of(d) + 2) ? 0 : m_k[d] + 1;
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  initial begin
    forever begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        chk("mem_en",    d, 32'(mem_en_o[d]),    32'(m_k[d] == 1));
        chk("mem_we",    d, 32'(mem_we_o[d]),    32'((m_k[d] == 1) && m_we[d]));
        chk("busy",      d, 32'(busy_o[d]),      32'(m_k[d] != 0));
        chk("cpu_ready", d, 32'(cpu_ready_o[d]), 32'((m_k[d] == lat_of(d) + 2) && !m_own[d]));
        chk("dma_ready", d, 32'(dma_ready_o[d]), 32'((m_k[d] == lat_of(d) + 2) && m_own[d]));
        chk("owner",     d, 32'(owner_o[d]),     32'(m_own[d]));
        chk("mem_addr",  d, mem_addr_o[d],  m_addr[d]);
        chk("mem_wdata", d, mem_wdata_o[d], m_wdata[d]);
        chk("cpu_rdata", d, cpu_rdata_o[d], m_crd[d]);
        chk("dma_rdata", d, dma_rdata_o[d], m_drd[d]);
      end
    end
  end

  // Memory: data is valid only in the cycle MEM_LAT after the strobe, noise otherwise.
  int since [3] = '{-1, -1, -1};
  bit grant_q [$];
  initial begin
    forever begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        if (!reset) since[d] = -1;
        else if (mem_en_o[d] === 1'b1) since[d] = 0;
        else if (since[d] >= 0 && since[d] < 100) since[d]++;
        mem_rdata_i[d] = (since[d] == lat_of(d)) ? mem_f(mem_addr_o[d]) : $urandom;
      end
      if (reset && mem_en_o[0] === 1'b1) grant_q.push_back(owner_o[0]);
    end
  end

  int          ready_at [3];
  int          cr_cnt   [3];
  int          dr_cnt   [3];
  int          en_cnt   [3];
  logic [31:0] en_addr  [3];
  logic [31:0] en_wdata [3];
  logic        en_we    [3];
  logic        en_own   [3];
  logic        busy_aft [3];

  // Observe n cycles after a grant edge; optionally drop requests and change addresses after the grant.
  task automatic run_obs(input int n, input bit drop);
    for (int d = 0; d < 3; d++) begin
      ready_at[d] = -1; cr_cnt[d] = 0; dr_cnt[d] = 0; en_cnt[d] = 0;
      en_addr[d] = '0; en_wdata[d] = '0; en_we[d] = 0; en_own[d] = 0; busy_aft[d] = 1'bx;
    end
    for (int i = 1; i <= n; i++) begin
      @(negedge clk); #1;
      if (i == 1 && drop) begin
        cpu_req = 0; dma_req = 0; cpu_addr = 32'h80; dma_addr = 32'h180;
      end
      for (int d = 0; d < 3; d++) begin
        if (cpu_ready_o[d] || dma_ready_o[d]) begin
          if (ready_at[d] < 0) ready_at[d] = i;
        end
        if (cpu_ready_o[d]) cr_cnt[d]++;
        if (dma_ready_o[d]) dr_cnt[d]++;
        if (mem_en_o[d]) begin
          en_cnt[d]++; en_addr[d] = mem_addr_o[d]; en_wdata[d] = mem_wdata_o[d];
          en_we[d] = mem_we_o[d]; en_own[d] = owner_o[d];
        end
        if (ready_at[d] > 0 && i == ready_at[d] + 1) busy_aft[d] = busy_o[d];
      end
    end
  endtask

  task automatic chk_all_zero(input string name);
    for (int d = 0; d < 3; d++) begin
      chk(name, d, cpu_rdata_o[d] | dma_rdata_o[d] | mem_addr_o[d] | mem_wdata_o[d] |
                   32'({cpu_ready_o[d], dma_ready_o[d], mem_en_o[d], mem_we_o[d], busy_o[d], owner_o[d]}),
          32'h0);
    end
  endtask

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  bit exp_order [8] = '{0, 0, 0, 1, 0, 0, 0, 1};
  int exp_lat   [3] = '{4, 3, 17};

  initial begin
    // Reset state
    @(negedge clk); #1;
    chk_all_zero("reset_state");
    @(negedge clk); @(negedge clk); #2;
    reset = 1;
    @(negedge clk); @(negedge clk); #2;

    // Single CPU read at 0x40; request dropped and address changed after the grant
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h40; cpu_wdata = 32'h0BAD0BAD;
    run_obs(25, 1);
    for (int d = 0; d < 3; d++) begin
      chk("rd_ready_lat", d, 32'(ready_at[d]), 32'(exp_lat[d]));
      chk("rd_cpu_ready_cnt", d, 32'(cr_cnt[d]), 32'd1);
      chk("rd_dma_ready_cnt", d, 32'(dr_cnt[d]), 32'd0);
      chk("rd_mem_en_cnt", d, 32'(en_cnt[d]), 32'd1);
      chk("rd_mem_addr", d, en_addr[d], 32'h40);
      chk("rd_cpu_rdata", d, cpu_rdata_o[d], 32'hDEADBEEF);
      chk("rd_busy_after", d, 32'(busy_aft[d]), 32'd0);
    end

    // DMA write
    @(negedge clk); #2;
    dma_req = 1; dma_we = 1; dma_addr = 32'h100; dma_wdata = 32'h12345678;
    run_obs(25, 1);
    for (int d = 0; d < 3; d++) begin
      chk("wr_ready_lat", d, 32'(ready_at[d]), 32'(exp_lat[d]));
      chk("wr_dma_ready_cnt", d, 32'(dr_cnt[d]), 32'd1);
      chk("wr_cpu_ready_cnt", d, 32'(cr_cnt[d]), 32'd0);
      chk("wr_mem_we", d, 32'(en_we[d]), 32'd1);
      chk("wr_mem_wdata", d, en_wdata[d], 32'h12345678);
      chk("wr_owner", d, 32'(en_own[d]), 32'd1);
      chk("wr_cpu_rdata", d, cpu_rdata_o[d], 32'hDEADBEEF);
      chk("wr_dma_rdata", d, dma_rdata_o[d], 32'h0);
    end

    // Both requesting continuously: starvation limit forces every fourth grant to DMA
    @(negedge clk); #2;
    grant_q.delete();
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h40;
    dma_req = 1; dma_we = 0; dma_addr = 32'h300;
    run_obs(38, 0);
    cpu_req = 0; dma_req = 0;
    chk("starve_grant_count", 0, 32'(grant_q.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < grant_q.size()) chk("starve_grant_order", 0, 32'(grant_q[i]), 32'(exp_order[i]));
    end
    run_obs(20, 0);

    // Reset during WAIT, with a DMA request pending across release
    @(negedge clk); #2;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h44;
    @(negedge clk); @(negedge clk); #2;
    reset = 0; cpu_req = 0; dma_req = 1; dma_we = 0; dma_addr = 32'h200;
    #1;
    chk_all_zero("reset_mid_access");
    @(negedge clk); @(negedge clk); #2;
    reset = 1;
    @(negedge clk); #1;
    for (int d = 0; d < 3; d++) begin
      chk("post_reset_owner", d, 32'(owner_o[d]), 32'd1);
      chk("post_reset_mem_en", d, 32'(mem_en_o[d]), 32'd1);
      chk("post_reset_addr", d, mem_addr_o[d], 32'h200);
    end
    dma_req = 0;
    run_obs(20, 0);

    // Randomized traffic against the model, with one reset burst in the middle
    for (int i = 0; i < 2500; i++) begin
      @(negedge clk); #1;
      if (i == 1200) reset = 0;
      if (i == 1203) reset = 1;
      cpu_req   = ($urandom_range(0, 3) != 0);
      dma_req   = ($urandom_range(0, 2) == 0);
      cpu_we    = 1'($urandom);
      dma_we    = 1'($urandom);
      cpu_addr  = ($urandom_range(0, 3) == 0) ? 32'h40 : $urandom;
      dma_addr  = $urandom;
      cpu_wdata = $urandom;
      dma_wdata = $urandom;
    end
    cpu_req = 0; dma_req = 0;
    run_obs(20, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified instruction/data memory of the MicroMIPS multicycle datapath between two requesters: the CPU control FSM (fetch/load/store) and a DMA/program-loader port.
- Sequences each memory access of fixed latency and returns a one-cycle ready pulse. The CPU control unit uses that pulse to leave its memory states (fetch, load-read, store), so those states stall until ready.
- Fixed CPU priority, with a starvation limit that guarantees DMA progress.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LAT, 2, cycles from the mem_en cycle to valid mem_rdata; legal range 1..15
- STARVE_LIM, 3, consecutive CPU grants while dma_req is pending before DMA is forced; legal range 1..15

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- cpu_req  in  1  CPU access request, held until cpu_ready
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_rdata  out  DATA_W  registered CPU read data
- cpu_ready  out  1  one-cycle completion pulse to CPU
- dma_req, dma_we, dma_addr, dma_wdata  in  1/1/ADDR_W/DATA_W  DMA equivalents
- dma_rdata  out  DATA_W  registered DMA read data
- dma_ready  out  1  one-cycle completion pulse to DMA
- mem_en  out  1  memory strobe, exactly one cycle per access
- mem_we  out  1  memory write enable, valid with mem_en
- mem_addr  out  ADDR_W  latched access address
- mem_wdata  out  DATA_W  latched write data
- mem_rdata  in  DATA_W  memory read data
- busy  out  1  high in every state except IDLE
- owner  out  1  0 = CPU, 1 = DMA; owner of the current or last access

Behaviour:
- Reset (reset low, asynchronous):
  - state = IDLE, starve_cnt = 0.
  - All outputs 0, including rdata registers, owner, mem_addr and mem_wdata.
  - An in-flight access is abandoned with no ready pulse.
  - After reset is released, the first decision happens on the first rising edge.
- States: IDLE, ISSUE, WAIT, RESP. All outputs are registered or decoded from the registered state only; there is no combinational path from request inputs to outputs.
- IDLE: requests are sampled at the rising edge.
  - Neither request: stay in IDLE.
  - Only one request: grant that requester.
  - Both request: grant DMA if starve_cnt == STARVE_LIM, otherwise grant CPU.
  - On grant: latch we/addr/wdata into the mem_* registers, set owner, go to ISSUE.
- starve_cnt update, at each grant:
  - CPU granted with dma_req high: starve_cnt increments, saturating at STARVE_LIM.
  - DMA granted, or CPU granted with dma_req low: starve_cnt clears to 0.
- ISSUE: one cycle.
  - mem_en = 1; mem_we = latched we.
  - Load a down-counter with MEM_LAT-1; go to WAIT.
- WAIT:
  - mem_en = 0.
  - Counter decrements each cycle. When it reaches 0, mem_rdata is valid in that cycle.
  - On that edge: if the access is a read, capture mem_rdata into the owner's rdata register; go to RESP.
  - Duration of WAIT is exactly MEM_LAT cycles.
- RESP: one cycle.
  - The owner's ready = 1.
  - Next state is IDLE unconditionally.
- Writes: same timing as reads; rdata registers are unchanged.
- Latency: a request sampled in IDLE at edge t gives ISSUE in cycle t+1 and ready in cycle t+2+MEM_LAT. Back-to-back accesses take MEM_LAT+3 cycles each, because IDLE always occupies one cycle.
- A requester that drops req or changes its inputs after the grant edge does not affect the access: latched values are used and ready still pulses.
- A new request is never granted while busy; the requester's request is held until IDLE.
- Only the owner's ready pulses; the non-owner's ready and rdata stay unchanged.
- mem_addr, mem_wdata and owner hold their value until the next grant.
- Counter and state need no wrap handling beyond the MEM_LAT range; parameters outside the legal range are unsupported.

Test Plan:
- Reset / single CPU read: MEM_LAT=2. Assert reset low, release; cpu_req=1, cpu_we=0, cpu_addr=0x40, memory returns 0xDEADBEEF -> mem_en is high for exactly one cycle with mem_addr=0x40, cpu_ready pulses 4 cycles after the grant edge, cpu_rdata=0xDEADBEEF, dma_ready stays 0, busy low again one cycle later.
- DMA write: dma_req=1, dma_we=1, dma_addr=0x100, dma_wdata=0x12345678 -> mem_we=1 with mem_en, mem_wdata=0x12345678, owner=1, dma_ready pulses once, cpu_rdata and dma_rdata unchanged.
- Simultaneous requests with starvation: STARVE_LIM=3, cpu_req and dma_req held high continuously -> grant order CPU, CPU, CPU, DMA, CPU, CPU, CPU, DMA; starve_cnt returns to 0 after each DMA grant.
- Request drop: cpu_req is dropped in the cycle after the grant, and cpu_addr changes to 0x80 -> access still uses 0x40 and cpu_ready still pulses; no second access starts.
- Reset mid-access: reset is asserted low during WAIT -> all outputs read 0 immediately, no ready pulse occurs; after release, a pending dma_req is granted on the first edge.
- Latency sweep: MEM_LAT=1 and MEM_LAT=15 -> cpu_ready arrives at grant+3 and grant+17 cycles respectively; mem_en is one cycle wide in both cases.
